// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared state encoding and defaults for the memory port arbiter
package mem_port_arbiter_pkg;
  typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_DONE} arb_state_t;
  localparam int MEM_LAT_DEF = 2;
  localparam int STARVE_DEF = 4;
endpackage

// File: rtl/mem_port_arbiter_lat_timer.sv
// mem_lat_timer: 4-bit load/decrement latency counter with a done flag
module mem_lat_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       dec,
  input  logic [3:0] load_val,
  output logic       done
);
  logic [3:0] cnt;
  always_ff @(posedge clk)
    cnt <= reset ? 4'd0 : load ? load_val : (dec && cnt != 4'd0) ? cnt - 4'd1 : cnt;
  assign done = cnt == 4'd0;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency memory port between fetch and data stages
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int WORD    = 32,
  parameter int ADDR_W  = 10,
  parameter int MEM_LAT = MEM_LAT_DEF,
  parameter int STARVE  = STARVE_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [WORD-1:0]   if_rdata,
  output logic              if_valid,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [WORD-1:0]   dm_wdata,
  output logic [WORD-1:0]   dm_rdata,
  output logic              dm_valid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD-1:0]   mem_wdata,
  input  logic [WORD-1:0]   mem_rdata,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              busy
);
  arb_state_t state, state_nx;
  logic       win_dm, we_q, lat_done, grant, grant_if, capture;
  logic [3:0] starve_cnt;
  assign grant    = state == ARB_IDLE && (if_req || dm_req);
  assign grant_if = if_req && (!dm_req || starve_cnt == 4'(STARVE));
  assign capture  = state == ARB_WAIT && lat_done;
  mem_lat_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (state == ARB_ISSUE),
    .dec      (state == ARB_WAIT),
    .load_val (4'(MEM_LAT - 1)),
    .done     (lat_done)
  );
  always_ff @(posedge clk)
    state <= reset ? ARB_IDLE : state_nx;
  always_comb
    state_nx = state == ARB_IDLE  ? (grant ? ARB_ISSUE : ARB_IDLE) :
               state == ARB_ISSUE ? ARB_WAIT :
               state == ARB_WAIT  ? (lat_done ? ARB_DONE : ARB_WAIT) : ARB_IDLE;
  always_comb begin
    mem_en   = state == ARB_ISSUE;
    mem_we   = mem_en && win_dm && we_q;
    if_valid = state == ARB_DONE && !win_dm;
    dm_valid = state == ARB_DONE && win_dm;
    busy     = state != ARB_IDLE;
  end
  assign stall_if  = if_req && !if_valid;
  assign stall_mem = dm_req && !dm_valid;
  always_ff @(posedge clk)
    if (reset) begin
      win_dm     <= 1'b0;
      we_q       <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      starve_cnt <= '0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
    end else begin
      if (grant) begin
        win_dm     <= !grant_if;
        we_q       <= !grant_if && dm_we;
        mem_addr   <= grant_if ? if_addr : dm_addr;
        mem_wdata  <= grant_if ? '0 : dm_wdata;
        starve_cnt <= (grant_if || !if_req) ? 4'd0 :
                      starve_cnt == 4'(STARVE) ? starve_cnt : starve_cnt + 4'd1;
      end
      if (capture && !win_dm) if_rdata <= mem_rdata;
      if (capture && win_dm && !we_q) dm_rdata <= mem_rdata;
    end
endmodule
